spi_cfg_ctrl: RTL and testbench

// - SPI-slave configuration controller for the demoscene: decodes host commands from

---
 rtl/demoscene_pkg.sv | 25 ++
 rtl/spi_byte_rx.sv | 61 ++++++
 rtl/spi_cfg_ctrl.sv | 156 +++++++++++++++
 tb/tb_spi_cfg_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/demoscene_pkg.sv
// Shared command-field positions, FSM state type and register map for the
// demoscene SPI configuration controller.
package demoscene_pkg;

    localparam int CMD_RW_BIT   = 7;
    localparam int CMD_RSVD_MSB = 6;
    localparam int CMD_RSVD_LSB = 4;
    localparam int CMD_ADDR_W   = 4;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WDATA,
        RDATA,
        ERR
    } cfg_state_t;

    localparam int REG_PALETTE0 = 0;
    localparam int REG_PALETTE1 = 1;
    localparam int REG_PALETTE2 = 2;
    localparam int REG_PALETTE3 = 3;
    localparam int REG_SCROLL   = 4;
    localparam int REG_PWM_TONE = 5;

endpackage

// File: rtl/spi_byte_rx.sv
// SPI mode-0 byte receiver: synchronizes the async pins into clk, detects SCLK
// edges and assembles MSB-first bytes, flagging each completed byte.
module spi_byte_rx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              ssel,
    input  logic              mosi,
    output logic [DATA_W-1:0] rx_byte,
    output logic              byte_valid,
    output logic              sclk_fall,
    output logic              ssel_s
);
    localparam int CW = $clog2(DATA_W);

    logic [1:0]        r_sclk_sync;
    logic [1:0]        r_ssel_sync;
    logic [1:0]        r_mosi_sync;
    logic              r_sclk_d;
    logic [CW-1:0]     r_bit_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_byte_valid;
    logic              w_sclk_s;
    logic              w_sclk_rise;

    assign w_sclk_s    = r_sclk_sync[1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign sclk_fall   = ~w_sclk_s & r_sclk_d;
    assign ssel_s      = r_ssel_sync[1];
    assign rx_byte     = r_shift;
    assign byte_valid  = r_byte_valid;

    // Select resets deasserted so nothing looks like a transaction right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync  <= 2'b00;
            r_ssel_sync  <= 2'b11;
            r_mosi_sync  <= 2'b00;
            r_sclk_d     <= 1'b0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
        end else begin
            r_sclk_sync  <= {r_sclk_sync[0], sclk};
            r_ssel_sync  <= {r_ssel_sync[0], ssel};
            r_mosi_sync  <= {r_mosi_sync[0], mosi};
            r_sclk_d     <= w_sclk_s;
            r_byte_valid <= 1'b0;
            if (ssel_s) begin
                r_bit_cnt <= '0;
            end else if (w_sclk_rise) begin
                r_shift      <= {r_shift[DATA_W-2:0], r_mosi_sync[1]};
                r_bit_cnt    <= r_bit_cnt + 1'b1;
                r_byte_valid <= (r_bit_cnt == CW'(DATA_W - 1));
            end
        end
    end

endmodule

// File: rtl/spi_cfg_ctrl.sv
// SPI-slave config controller: host writes land in staging and are copied to the
// active registers only at frame_start. Define SPI_READBACK_EN for miso read-back.
module spi_cfg_ctrl
    import demoscene_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sclk,
    input  logic                       ssel,
    input  logic                       mosi,
    output logic                       miso,
    input  logic                       frame_start,
    output logic [NUM_REGS*DATA_W-1:0] cfg_regs,
    output logic                       cfg_update,
    output logic                       cmd_err
);
    localparam int AW = $clog2(NUM_REGS);

    logic [DATA_W-1:0]          w_rx_byte;
    logic                       w_byte_valid;
    logic                       w_sclk_fall;
    logic                       w_ssel_s;
    cfg_state_t                 r_state;
    cfg_state_t                 w_next;
    logic [AW-1:0]              r_addr;
    logic [AW-1:0]              w_cmd_addr;
    logic [AW-1:0]              w_ld_addr;
    logic [NUM_REGS*DATA_W-1:0] r_staging;
    logic [NUM_REGS*DATA_W-1:0] r_active;
    logic                       r_pending;
    logic                       r_cfg_update;
    logic                       r_cmd_err;
    logic                       w_cmd_rw;
    logic                       w_cmd_legal;
    logic                       w_cmd_done;
    logic                       w_cmd_bad;
    logic                       w_stage_we;
    logic                       w_rd_load;
    logic                       w_commit;

    spi_byte_rx #(.DATA_W(DATA_W)) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclk       (sclk),
        .ssel       (ssel),
        .mosi       (mosi),
        .rx_byte    (w_rx_byte),
        .byte_valid (w_byte_valid),
        .sclk_fall  (w_sclk_fall),
        .ssel_s     (w_ssel_s)
    );

    assign w_cmd_rw   = w_rx_byte[CMD_RW_BIT];
    assign w_cmd_addr = w_rx_byte[AW-1:0];
    assign w_ld_addr  = w_cmd_done ? w_cmd_addr : r_addr;
`ifdef SPI_READBACK_EN
    assign w_cmd_legal = (w_rx_byte[CMD_RSVD_MSB:CMD_RSVD_LSB] == '0);
`else
    assign w_cmd_legal = (w_rx_byte[CMD_RSVD_MSB:CMD_RSVD_LSB] == '0) && w_cmd_rw;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_cmd_done = 1'b0;
        w_cmd_bad  = 1'b0;
        w_stage_we = 1'b0;
        w_rd_load  = 1'b0;
        case (r_state)
            IDLE:  if (!w_ssel_s) w_next = CMD;
            CMD: begin
                if (w_byte_valid) begin
                    if (w_cmd_legal) begin
                        w_cmd_done = 1'b1;
                        w_rd_load  = !w_cmd_rw;
                        w_next     = w_cmd_rw ? WDATA : RDATA;
                    end else begin
                        w_cmd_bad = 1'b1;
                        w_next    = ERR;
                    end
                end
            end
            WDATA: w_stage_we = w_byte_valid;
            RDATA: w_rd_load  = w_byte_valid;
            ERR:   w_next     = ERR;
            default: w_next   = IDLE;
        endcase
        if (w_ssel_s) w_next = IDLE;
    end

    // Commit only between transactions, so a frame never sees a half-written burst.
    assign w_commit = frame_start && r_pending && (r_state == IDLE) && w_ssel_s && !w_stage_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr       <= '0;
            r_staging    <= '0;
            r_active     <= '0;
            r_pending    <= 1'b0;
            r_cfg_update <= 1'b0;
            r_cmd_err    <= 1'b0;
        end else begin
            r_cfg_update <= w_commit;
            r_cmd_err    <= w_cmd_bad;
            if (w_cmd_done)
                r_addr <= w_cmd_addr + AW'(w_rd_load);
            else if (w_stage_we || w_rd_load)
                r_addr <= r_addr + 1'b1;
            if (w_stage_we)
                r_staging[r_addr*DATA_W +: DATA_W] <= w_rx_byte;
            if (w_commit) begin
                r_active  <= r_staging;
                r_pending <= 1'b0;
            end else if (w_stage_we) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign cfg_regs   = r_active;
    assign cfg_update = r_cfg_update;
    assign cmd_err    = r_cmd_err;

`ifdef SPI_READBACK_EN
    logic [DATA_W-1:0] r_tx;
    logic              r_tx_fresh;

    // A fresh load already presents its MSB, so the first falling edge after it is skipped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx       <= '0;
            r_tx_fresh <= 1'b0;
        end else if (w_rd_load) begin
            r_tx       <= r_active[w_ld_addr*DATA_W +: DATA_W];
            r_tx_fresh <= 1'b1;
        end else if (w_sclk_fall) begin
            if (r_tx_fresh) r_tx_fresh <= 1'b0;
            else            r_tx       <= {r_tx[DATA_W-2:0], 1'b0};
        end
    end

    assign miso = (r_state == RDATA) && !w_ssel_s && r_tx[DATA_W-1];
`else
    logic w_unused_rd;
    assign w_unused_rd = w_sclk_fall ^ w_rd_load ^ (|w_ld_addr);
    assign miso        = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cfg_ctrl.sv
// Scoreboard bench for spi_cfg_ctrl: drives SPI mode-0 transactions and frame pulses,
// predicting commits, cmd_err pulses and miso bytes from a register-map model.
module tb_spi_cfg_ctrl;
    localparam int NREG = 16;
`ifdef SPI_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            sclk = 1'b0;
    logic            ssel = 1'b1;
    logic            mosi = 1'b0;
    logic            frame_start = 1'b0;
    logic            miso;
    logic            cfg_update;
    logic            cmd_err;
    logic [NREG*8-1:0] cfg_regs;

    int checks = 0;
    int errors = 0;

    logic [7:0]        modelStage [NREG];
    logic [7:0]        modelActive[NREG];
    bit                modelPending;
    logic [NREG*8-1:0] expCommitQ[$];
    bit                expErrQ[$];
    logic [7:0]        expMisoQ[$];
    logic [7:0]        txBytes[8];
    int                txLen;
    logic [NREG*8-1:0] expVec;
    logic [7:0]        expByte;
    int                misoCnt = 0;
    logic [7:0]        misoShift = 8'h00;

    spi_cfg_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sclk        (sclk),
        .ssel        (ssel),
        .mosi        (mosi),
        .miso        (miso),
        .frame_start (frame_start),
        .cfg_regs    (cfg_regs),
        .cfg_update  (cfg_update),
        .cmd_err     (cmd_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [NREG*8-1:0] packActive();
        logic [NREG*8-1:0] v;
        v = '0;
        for (int i = 0; i < NREG; i++) v[i*8 +: 8] = modelActive[i];
        return v;
    endfunction

    task automatic waitClk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic spiByte(input logic [7:0] b, input int nbits, input logic [7:0] em, input bit push);
        if (push) expMisoQ.push_back(em);
        for (int i = 0; i < nbits; i++) begin
            mosi = b[7-i];
            waitClk(8);
            sclk = 1'b1;
            waitClk(8);
            sclk = 1'b0;
        end
    endtask

    task automatic framePulse();
        if (ssel && modelPending) begin
            for (int i = 0; i < NREG; i++) modelActive[i] = modelStage[i];
            modelPending = 1'b0;
            expCommitQ.push_back(packActive());
        end
        frame_start = 1'b1;
        waitClk(1);
        frame_start = 1'b0;
        waitClk(3);
    endtask

    task automatic modelReset();
        for (int i = 0; i < NREG; i++) begin
            modelStage[i]  = 8'h00;
            modelActive[i] = 8'h00;
        end
        modelPending = 1'b0;
    endtask

    task automatic applyStimulus(input int abortBits, input bit midFrame, input bit midReset);
        logic [7:0] cmd;
        logic [7:0] em;
        bit         legal;
        bit         isWr;
        int         a;
        cmd   = txBytes[0];
        isWr  = cmd[7];
        legal = (cmd[6:4] == 3'b000) && (isWr || READBACK);
        a     = int'(cmd[3:0]);
        ssel  = 1'b0;
        waitClk(4);
        if (!legal) expErrQ.push_back(1'b1);
        spiByte(cmd, 8, 8'h00, 1'b1);
        for (int k = 1; k < txLen; k++) begin
            em = 8'h00;
            if (legal && !isWr) em = modelActive[(a + k - 1) % NREG];
            spiByte(txBytes[k], 8, em, 1'b1);
            if (legal && isWr) begin
                modelStage[(a + k - 1) % NREG] = txBytes[k];
                modelPending = 1'b1;
            end
            if (midFrame && k == 1) framePulse();
        end
        if (abortBits > 0) spiByte(8'($urandom), abortBits, 8'h00, 1'b0);
        if (midReset) begin
            rst_n = 1'b0;
            ssel  = 1'b1;
            sclk  = 1'b0;
            mosi  = 1'b0;
            waitClk(3);
            rst_n = 1'b1;
            modelReset();
            waitClk(4);
            checkOutput("cfg_regs after mid-transaction reset", 128'(cfg_regs), 128'(0));
        end else begin
            ssel = 1'b1;
            waitClk(6);
        end
    endtask

    // Commit and error-pulse monitor, decoupled from the stimulus thread.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cfg_update) begin
                if (expCommitQ.size() == 0) begin
                    checkOutput("unexpected cfg_update", 128'(cfg_update), 128'(0));
                end else begin
                    expVec = expCommitQ.pop_front();
                    checkOutput("cfg_regs at commit", 128'(cfg_regs), 128'(expVec));
                end
            end
            if (cmd_err) begin
                checkOutput("cmd_err pulse expected", 128'(cmd_err), 128'(expErrQ.size() != 0));
                if (expErrQ.size() != 0) void'(expErrQ.pop_front());
            end
        end
    end

    // miso is sampled by the host on raw SCLK rising edges, MSB first.
    always @(posedge sclk or posedge ssel) begin
        if (ssel) begin
            misoCnt = 0;
        end else begin
            misoShift = {misoShift[6:0], miso};
            misoCnt++;
            if (misoCnt == 8) begin
                misoCnt = 0;
                if (expMisoQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL miso byte: got %h with no expected byte queued", misoShift);
                end else begin
                    expByte = expMisoQ.pop_front();
                    checkOutput("miso byte", 128'(misoShift), 128'(expByte));
                end
            end
        end
    end

    initial begin
        #800000;
        errors++;
        $display("[TB] FAIL timeout: simulation did not complete within the time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        modelReset();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        waitClk(4);
        checkOutput("reset cfg_regs", 128'(cfg_regs), 128'(0));
        checkOutput("reset miso", 128'(miso), 128'(0));
        checkOutput("reset cfg_update", 128'(cfg_update), 128'(0));
        checkOutput("reset cmd_err", 128'(cmd_err), 128'(0));

        txBytes[0] = 8'h81; txBytes[1] = 8'h5A; txBytes[2] = 8'h3C; txLen = 3;
        applyStimulus(0, 1'b0, 1'b0);
        framePulse();

        txBytes[0] = 8'h8F; txBytes[1] = 8'h11; txBytes[2] = 8'h22; txLen = 3;
        applyStimulus(0, 1'b0, 1'b0);
        framePulse();

        txBytes[0] = 8'h83; txBytes[1] = 8'h77; txLen = 2;
        applyStimulus(0, 1'b1, 1'b0);
        framePulse();

        txBytes[0] = 8'h90; txBytes[1] = 8'hFF; txLen = 2;
        applyStimulus(0, 1'b0, 1'b0);
        framePulse();

        txBytes[0] = 8'h84; txBytes[1] = 8'hAB; txLen = 2;
        applyStimulus(4, 1'b0, 1'b0);
        framePulse();

        txBytes[0] = 8'h82; txBytes[1] = 8'hC3; txLen = 2;
        applyStimulus(0, 1'b0, 1'b0);
        framePulse();
        txBytes[0] = 8'h02; txBytes[1] = 8'h00; txBytes[2] = 8'h00; txLen = 3;
        applyStimulus(0, 1'b0, 1'b0);

        txBytes[0] = 8'h85; txBytes[1] = 8'h66; txLen = 2;
        applyStimulus(3, 1'b0, 1'b1);
        framePulse();
        txBytes[0] = 8'h86; txBytes[1] = 8'h99; txLen = 2;
        applyStimulus(0, 1'b0, 1'b0);
        framePulse();

        for (int t = 0; t < 30; t++) begin
            int         kind;
            logic [3:0] addr;
            kind = $urandom_range(0, 9);
            addr = 4'($urandom_range(0, 15));
            if (kind == 0)     txBytes[0] = {1'($urandom), 3'($urandom_range(1, 7)), addr};
            else if (kind < 3) txBytes[0] = {4'b0000, addr};
            else               txBytes[0] = {4'b1000, addr};
            txLen = 1 + $urandom_range(0, 4);
            for (int k = 1; k < txLen; k++) txBytes[k] = 8'($urandom);
            applyStimulus(($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0,
                          $urandom_range(0, 4) == 0, 1'b0);
            if ($urandom_range(0, 1) == 1) framePulse();
        end

        framePulse();
        waitClk(4);
        checkOutput("final cfg_regs", 128'(cfg_regs), 128'(packActive()));
        checkOutput("commit queue drained", 128'(expCommitQ.size()), 128'(0));
        checkOutput("cmd_err queue drained", 128'(expErrQ.size()), 128'(0));
        checkOutput("miso queue drained", 128'(expMisoQ.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
